serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor: diff = a - b, processed LSB-first.
- Each cycle, one full-subtractor cell operates on one bit pair plus the registered borrow.
- The cell's borrow output is fed back through a flip-flop.
- Downstream consumer of the full-subtractor cell: turns the single-bit combinational stage into a multi-bit sequential datapath with a start/done handshake.

Parameters:
- WIDTH, 8, operand and result width in bits (legal ≥ 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while in RUN or DONE.
- done  output  1  one-cycle pulse when result is valid.
- diff  output  WIDTH  result register (a - b mod 2^WIDTH).
- borrow_out  output  1  final borrow; 1 iff a < b (unsigned).

Behaviour:
- Reset: one clock; reset is synchronous and active-high, sampled on the rising edge of clk.
  - state = IDLE.
  - busy = 0, done = 0, diff = 0, borrow_out = 0.
  - Internal shift registers, borrow flop and bit counter cleared.
- Reset has priority over all other inputs in every state, including mid-RUN: the operation is abandoned and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start = 1 at edge k: latch a and b into shift registers sa and sb, borrow flop br = 0, count = 0, go to RUN.
  - diff and borrow_out hold their previous values.
- RUN, each edge:
  - d = sa[0] ^ sb[0] ^ br
  - bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
  - sa and sb shift right by 1; d shifts into the MSB of result shift register sr; br = bo; count += 1.
- RUN completion: on the edge where count = WIDTH-1 (the WIDTH-th RUN edge, edge k+WIDTH):
  - diff is loaded with the final sr value (including this bit).
  - borrow_out is loaded with this cycle's bo.
  - state goes to DONE.
- DONE: done = 1 for exactly this one cycle; unconditional return to IDLE on the next edge.
- Latency: start sampled at edge k → done high during the cycle after edge k+WIDTH. Next start accepted at edge k+WIDTH+2 at the earliest.
- busy = 1 in RUN and DONE; 0 in IDLE.
- start while busy is ignored; no queuing.
- a and b may change freely after the accepting edge without affecting the operation.
- diff and borrow_out change only at completion or reset. They never show partial results and hold until the next completion.
- Arithmetic: unsigned two's-complement wrap.
  - a = b → diff = 0, borrow_out = 0.
  - a = 0, b = 2^WIDTH-1 → diff = 1, borrow_out = 1.
- count width: clog2(WIDTH) bits; must not overflow for any legal WIDTH.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, start pulse at edge k → done high exactly one cycle after edge k+8; diff=0x23, borrow_out=0; busy high for 9 cycles.
- a=0x12, b=0x35 → diff=0xDD, borrow_out=1. a=0x00, b=0x01 → diff=0xFF, borrow_out=1. a=0xFF, b=0xFF → diff=0x00, borrow_out=0.
- Start a=0x80, b=0x01, then pulse start with a=0x00, b=0x00 during RUN and again during DONE, changing a/b mid-run → single done, diff=0x7F, borrow_out=0; no second operation starts.
- Complete a=0x0A-0x03 (diff=0x07), then start 0x50-0x20 and assert rst at the 4th RUN edge → next cycle state IDLE, busy=0, diff=0x00, borrow_out=0, no done pulse; fresh start afterwards yields diff=0x30.
- WIDTH=3, exhaustive 64 (a,b) pairs, back-to-back starts at earliest legal edge → diff=(a-b)&7 and borrow_out=(a<b) for every pair; done count = 64.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial unsigned subtractor, diff = a - b, LSB first.
// One full-subtractor cell handles one bit pair per cycle. Its borrow output
// is registered and fed back into the next bit. A start/done handshake
// wraps the datapath.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    // The counter runs 0..WIDTH-1, so clog2(WIDTH) bits always suffice.
    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sa;     // minuend shift register
    logic [WIDTH-1:0] sb;     // subtrahend shift register
    logic [WIDTH-1:0] sr;     // result shift register, filled from the MSB end
    logic             br;     // registered borrow from the previous bit
    logic [CW-1:0]    count;  // index of the bit being processed
    logic             d;
    logic             bo;

    // Full-subtractor cell: current LSB pair plus the registered borrow.
    always_comb begin
        d  = sa[0] ^ sb[0] ^ br;
        bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: flops use non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: capture the operands on start, shift one bit per RUN cycle, publish the result at completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            sa         <= '0;
            sb         <= '0;
            sr         <= '0;
            br         <= 1'b0;
            count      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b;
                        sr    <= '0;
                        br    <= 1'b0;
                        count <= '0;
                    end
                end
                RUN: begin
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    sr    <= {d, sr[WIDTH-1:1]};
                    br    <= bo;
                    count <= count + CW'(1);
                    // The last bit goes straight into diff, so diff never shows a partial result.
                    if (count == LAST) begin
                        diff       <= {d, sr[WIDTH-1:1]};
                        borrow_out <= bo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor. It uses an 8-bit instance for the
// scenario tests and a 3-bit instance for the exhaustive back-to-back sweep.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       bo8;

    logic       start3 = 1'b0;
    logic [2:0] a3 = '0;
    logic [2:0] b3 = '0;
    logic       busy3;
    logic       done3;
    logic [2:0] diff3;
    logic       bo3;

    int n_cmp = 0;
    int n_bad = 0;
    int done3_cnt = 0;

    serial_subtractor #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor #(.WIDTH(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
        .busy(busy3), .done(done3), .diff(diff3), .borrow_out(bo3)
    );

    always #5 clk = ~clk;

    // Count every done pulse of the 3-bit instance on the inactive edge.
    always @(negedge clk) begin
        if (done3) done3_cnt++;
    end

    // Issue one start pulse. Return the cycle (after the accepting edge) on which done
    // was seen, and the number of cycles busy was high.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                        output int lat, output int busy_cnt);
        @(posedge clk); #1;
        a8 = av; b8 = bv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1;
        busy_cnt = 0;
        for (int n = 0; n < 40; n++) begin
            if (busy8) busy_cnt++;
            if (done8 && lat < 0) lat = n;
            if (!busy8 && lat >= 0) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset8: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy8, done8, diff8, bo8);
        end
        n_cmp++;
        if ({busy3, done3, diff3, bo3} !== 6'd0) begin
            n_bad++;
            $display("FAIL reset3: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy3, done3, diff3, bo3);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vd [4];
        logic       vbo [4];
        int lat, bc;
        va = '{8'h35, 8'h12, 8'h00, 8'hFF};
        vb = '{8'h12, 8'h35, 8'h01, 8'hFF};
        vd = '{8'h23, 8'hDD, 8'hFF, 8'h00};
        vbo = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run8(va[i], vb[i], lat, bc);
            n_cmp++;
            if (lat !== 8) begin
                n_bad++;
                $display("FAIL latency[%0d]: got %0d, want 8", i, lat);
            end
            n_cmp++;
            if (bc !== 9) begin
                n_bad++;
                $display("FAIL busy_cycles[%0d]: got %0d, want 9", i, bc);
            end
            n_cmp++;
            if (diff8 !== vd[i] || bo8 !== vbo[i]) begin
                n_bad++;
                $display("FAIL basic[%0d] %h-%h: got diff=%h bo=%b, want diff=%h bo=%b",
                         i, va[i], vb[i], diff8, bo8, vd[i], vbo[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int n = 0; n < 30; n++) begin
            if (done8) dones++;
            // Extra start requests during RUN and DONE, with new operands.
            if (n == 3) begin a8 = 8'h00; b8 = 8'h00; start8 = 1'b1; end
            else if (n == 4) begin start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA; end
            else if (n == 8) begin a8 = 8'h00; b8 = 8'h00; start8 = 1'b1; end
            else if (n == 9) start8 = 1'b0;
            if (n == 9) begin
                n_cmp++;
                if (busy8 !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ignore_busy: got busy=%b after DONE, want 0", busy8);
                end
            end
            if (n > 9 && busy8) begin
                n_bad++; n_cmp++;
                $display("FAIL ignore_restart: got busy=1 at cycle %0d, want 0", n);
                break;
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL ignore_dones: got %0d done pulses, want 1", dones);
        end
        n_cmp++;
        if (diff8 !== 8'h7F || bo8 !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore_result: got diff=%h bo=%b, want diff=7f bo=0", diff8, bo8);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, dones;
        run8(8'h0A, 8'h03, lat, bc);
        n_cmp++;
        if (diff8 !== 8'h07 || bo8 !== 1'b0) begin
            n_bad++;
            $display("FAIL pre_reset: got diff=%h bo=%b, want diff=07 bo=0", diff8, bo8);
        end
        @(posedge clk); #1;
        a8 = 8'h50; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk); #1;      // accepting edge k
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;                      // after edge k+3
        rst = 1'b1;
        @(posedge clk); #1;      // edge k+4 samples reset
        rst = 1'b0;
        n_cmp++;
        if ({busy8, done8, diff8, bo8} !== 11'd0) begin
            n_bad++;
            $display("FAIL mid_reset: got busy=%b done=%b diff=%h bo=%b, want all 0",
                     busy8, done8, diff8, bo8);
        end
        dones = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL mid_reset_quiet: got %0d active cycles, want 0", dones);
        end
        run8(8'h50, 8'h20, lat, bc);
        n_cmp++;
        if (lat !== 8 || diff8 !== 8'h30 || bo8 !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: got lat=%0d diff=%h bo=%b, want lat=8 diff=30 bo=0",
                     lat, diff8, bo8);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ea;
        logic [2:0] eb;
        logic [2:0] ed;
        logic       eo;
        int         base;
        base = done3_cnt;
        @(posedge clk); #1;
        a3 = 3'd0; b3 = 3'd0; start3 = 1'b1;
        for (int p = 0; p < 64; p++) begin
            ea = 3'(p >> 3);
            eb = 3'(p);
            ed = ea - eb;
            eo = (ea < eb);
            @(posedge clk); #1;      // accepting edge k
            start3 = 1'b0;
            repeat (3) @(posedge clk);
            #1;                      // after edge k+3: DONE cycle
            n_cmp++;
            if (done3 !== 1'b1 || diff3 !== ed || bo3 !== eo) begin
                n_bad++;
                $display("FAIL b2b %0d-%0d: got done=%b diff=%0d bo=%b, want done=1 diff=%0d bo=%b",
                         ea, eb, done3, diff3, bo3, ed, eo);
            end
            if (p < 63) begin
                a3 = 3'((p + 1) >> 3);
                b3 = 3'(p + 1);
                start3 = 1'b1;
            end
            @(posedge clk); #1;      // after edge k+4: back in IDLE
        end
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (done3_cnt - base !== 64) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d done pulses, want 64", done3_cnt - base);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard bound on run time in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

endmodule
